// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl
// Load/store sequencing controller between the execute stage and the data
// memory bus. Takes one decoded memory request, runs a single req/ack bus
// transaction while stalling the core, formats byte enables / write data,
// extends load data, and reports rejected accesses and bus timeouts.
//
// Ports
//   clk_i, rstn_i          clock, synchronous active-low reset
//   core_req_i/we_i/size_i access request, direction, size (0=B 1=H 2=W 4=BU 5=HU)
//   core_addr_i/wd_i       byte address, store data
//   core_rd_o              extended load result (held until the next load completes)
//   core_stall_o           hold the core pipeline
//   core_misalign_o        one-cycle pulse: access rejected
//   core_fault_o           one-cycle pulse: bus timeout
//   m_req_o/we_o/be_o      bus request, write, byte enables
//   m_addr_o/wd_o          word address, lane-replicated write data
//   m_rd_i/ack_i           bus read data, transaction complete

module riscv_lsu_ctrl #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        core_fault_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wd_o,
    input  logic [31:0] m_rd_i,
    input  logic        m_ack_i
);

    localparam int             CW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] T_END = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        fault_q, fault_d;

    logic        illegal;
    logic [3:0]  be_fmt;
    logic [31:0] wd_fmt;
    logic [31:0] rd_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Access legality: unknown sizes, unsigned stores, and unaligned H/W.
    always_comb begin
        illegal = 1'b0;
        if (core_size_i == 3'd3 || core_size_i == 3'd6 || core_size_i == 3'd7)
            illegal = 1'b1;
        if (core_we_i && core_size_i[2])
            illegal = 1'b1;
        if (core_size_i[1:0] == 2'd1 && core_addr_i[0])
            illegal = 1'b1;
        if (core_size_i == 3'd2 && core_addr_i[1:0] != 2'd0)
            illegal = 1'b1;
    end

    // Store lane formatting; loads always enable the whole word.
    always_comb begin
        be_fmt = 4'b1111;
        wd_fmt = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                wd_fmt = {4{core_wd_i[7:0]}};
                if (core_we_i) be_fmt = 4'b0001 << core_addr_i[1:0];
            end
            2'd1: begin
                wd_fmt = {2{core_wd_i[15:0]}};
                if (core_we_i) be_fmt = 4'b0011 << core_addr_i[1:0];
            end
            default: ;
        endcase
    end

    // Load lane select and extension from the latched offset/size.
    always_comb begin
        rd_byte = m_rd_i[8*off_q +: 8];
        rd_half = off_q[1] ? m_rd_i[31:16] : m_rd_i[15:0];
        case (size_q)
            3'd0:    rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    rd_fmt = {24'd0, rd_byte};
            3'd1:    rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'd5:    rd_fmt = {16'd0, rd_half};
            default: rd_fmt = m_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i && !illegal) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = core_we_i;
                    size_d  = core_size_i;
                    off_d   = core_addr_i[1:0];
                    be_d    = be_fmt;
                    addr_d  = {core_addr_i[31:2], 2'b00};
                    wd_d    = wd_fmt;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // Ack has priority over a timeout landing in the same cycle.
                if (m_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rd_d = rd_fmt;
                end else if (cnt_q == T_END) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    if (!we_q) rd_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            fault_q <= fault_d;
        end
    end

    // Stall/misalign are combinational from the request in IDLE; both are
    // forced low while reset is held, even if the state register is stale.
    assign core_stall_o    = rstn_i && ((state_q == IDLE && core_req_i && !illegal) ||
                                        state_q == BUSY);
    assign core_misalign_o = rstn_i && state_q == IDLE && core_req_i && illegal;
    assign core_fault_o    = fault_q;
    assign core_rd_o       = rd_q;
    assign m_req_o         = req_q;
    assign m_we_o          = we_q;
    assign m_be_o          = be_q;
    assign m_addr_o        = addr_q;
    assign m_wd_o          = wd_q;

endmodule

// File: doc/riscv_lsu_ctrl.md
# riscv_lsu_ctrl

Load/store sequencing controller between the core execute stage and the data-memory bus. It accepts a memory request built from the decoder's mem_req/mem_we/mem_size fields, the ALU address and the rs2 data. It runs one bus transaction with a req/ack handshake, stalling the core until that transaction finishes. It formats byte enables and write data, and sign- or zero-extends read data. It flags misaligned or illegal accesses and bus timeouts.

## Interface
- ACK_TIMEOUT, 255: cycles in BUSY without m_ack_i before the transaction is aborted (1..65535).

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- core_req_i  in  1  memory access requested (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load result
- core_stall_o  out  1  hold the core pipeline
- core_misalign_o  out  1  one-cycle pulse: access rejected (misaligned or illegal size)
- core_fault_o  out  1  one-cycle pulse: bus timeout
- m_req_o  out  1  bus request
- m_we_o  out  1  bus write
- m_be_o  out  4  byte enables
- m_addr_o  out  32  word address, bits [1:0] forced 0
- m_wd_o  out  32  lane-replicated write data
- m_rd_i  in  32  bus read data, valid in the m_ack_i cycle
- m_ack_i  in  1  transaction complete

## Operation
FSM states: IDLE, BUSY, DONE.

**IDLE**
- core_stall_o = core_req_i & legal access (combinational).
- A legal access latches we, size, addr[1:0], word address, formatted wd and be, then moves to BUSY.
- An illegal access produces no bus activity. It asserts core_misalign_o for that cycle with core_stall_o=0, and the FSM stays in IDLE.
- Illegal conditions:
  - size 3, 6 or 7;
  - store with size 4 or 5;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0.

**BUSY**
- m_req_o=1 and core_stall_o=1. m_we_o, m_be_o, m_addr_o and m_wd_o come from registers and are stable for the whole state.
- Timeout counter, width $clog2(ACK_TIMEOUT+1), is cleared on entry and increments every cycle.
- On m_ack_i: for loads, capture the formatted m_rd_i into core_rd_o; then go to DONE.
- If the counter reaches ACK_TIMEOUT-1 with no ack: set the fault flag, set core_rd_o=0 for loads, and go to DONE.
- If ack and timeout occur in the same cycle, ack wins and no fault is raised.

**DONE**
- m_req_o=0, core_stall_o=0, core_fault_o = fault flag. The FSM then returns to IDLE.
- core_req_i is ignored in DONE, because it is still the completing instruction's request.

**Formatting, store**
- B: be = 0001<<addr[1:0], wd = {4{wd[7:0]}}.
- H: be = 0011<<addr[1:0], wd = {2{wd[15:0]}}.
- W: be = 1111, wd unchanged.
- Loads drive be=1111.

**Formatting, load**
- Select byte addr[1:0] or halfword addr[1]; sign-extend for B/H, zero-extend for BU/HU; W unchanged.
- Stores leave core_rd_o unchanged.
- core_rd_o holds its value until the next completing load.

## Timing
- Reset values: state IDLE; core_rd_o=0, m_req_o=0, m_we_o=0, m_be_o=0, m_addr_o=0, m_wd_o=0, core_fault_o=0; counter=0. core_stall_o and core_misalign_o are 0 while rstn_i=0.
- Reset asserted mid-BUSY: m_req_o is low after that edge, and any ack is ignored.
- Latency: request in cycle 0, m_req_o high from cycle 1, ack in cycle k≥1, core_rd_o valid and core_stall_o low in cycle k+1. The minimum stall is 2 cycles (cycles 0 and 1).
- Back-to-back requests: a new core_req_i is accepted in the IDLE cycle right after DONE, so there are 3 cycles per access with zero-wait ack.
- m_ack_i is ignored outside BUSY.
- Timeout: with no ack, DONE with core_fault_o=1 occurs in cycle ACK_TIMEOUT+1.
- core_misalign_o and core_fault_o are never high in the same cycle.

## Test plan
- **LW, zero-wait:** addr 0x104, ack in cycle 1 with m_rd_i=0xDEADBEEF.
  - m_addr_o=0x104, be=1111, m_we_o=0.
  - core_rd_o=0xDEADBEEF and stall low in cycle 2.
- **LB / LBU, 2-cycle wait:** addr 0x203, m_rd_i=0x80AA5511, ack in cycle 3.
  - LB: core_rd_o=0xFFFFFF80.
  - LBU: core_rd_o=0x00000080.
  - Stall high in cycles 0-3.
- **SH / SB formatting:**
  - SH to 0x302 with wd 0x1234ABCD: be=1100, m_wd_o=0xABCDABCD, m_we_o=1.
  - SB to 0x301: be=0010, m_wd_o=0xCDCDCDCD.
  - core_rd_o unchanged in both cases.
- **Illegal accesses** (LW at 0x102, SH at 0x301, store with size 4):
  - core_misalign_o=1 for one cycle each.
  - m_req_o never rises, stall stays 0.
- **Timeout:** ACK_TIMEOUT=4, LW with no ack.
  - m_req_o high in cycles 1-4.
  - core_fault_o=1 and core_rd_o=0 in cycle 5.
  - A subsequent access completes normally.
- **Reset mid-BUSY:** rstn_i=0 in cycle 2 of a wait-state load.
  - Cycle 3: m_req_o=0, state IDLE.
  - Ack in cycle 3 is ignored, core_rd_o=0.
